// File: rtl/cap17_div_pkg.sv
// Shared definitions for the CAP17 sequential divider: FSM encoding and
// iteration-counter sizing.
package cap17_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_ripple_sub.sv
// Combinational a-b built as a full-adder ripple chain on a + ~b + 1.
// The borrow output is the inverted final carry.
module ripple_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0]   carry_s;
    logic [N-1:0] b_inv_s;

    assign carry_s[0] = 1'b1;
    assign b_inv_s    = ~b;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i]      = a[i] ^ b_inv_s[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b_inv_s[i]) | (carry_s[i] & (a[i] ^ b_inv_s[i]));
    end

    assign borrow = ~carry_s[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle,
// one-cycle done pulse, divide-by-zero flagged without any RUN cycles.
module seq_divider
    import cap17_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] q_r;
    // R's top bit is always zero because R < D; only the trial value needs WIDTH+1 bits.
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    cnt_r;

    logic             accept_s;
    logic             zero_div_s;
    logic             last_s;
    logic [WIDTH:0]   rs_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;
    logic             keep_s;
    logic [WIDTH-1:0] r_step_s;
    logic [WIDTH-1:0] q_step_s;

    assign accept_s   = start && (state_r != S_RUN);
    assign zero_div_s = (divisor == {WIDTH{1'b0}});
    assign last_s     = (cnt_r == LAST_CNT);
    assign rs_s       = {r_r, q_r[WIDTH-1]};

    ripple_sub #(.N(WIDTH + 1)) u_sub (
        .a      (rs_s),
        .b      ({1'b0, d_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // The chain borrow and T's sign bit agree whenever R < D; requiring both keeps a
    // corrupted partial remainder from ever being committed as a difference.
    assign keep_s   = ~diff_s[WIDTH] & ~borrow_s;
    assign r_step_s = keep_s ? diff_s[WIDTH-1:0] : rs_s[WIDTH-1:0];
    assign q_step_s = {q_r[WIDTH-2:0], keep_s};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start is honoured only from IDLE or DONE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt_s = zero_div_s ? S_DONE : S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they align with state_r
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt_s == S_RUN);
            done <= (state_nxt_s == S_DONE);
        end
    end

    // Operand capture, restoring iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r         <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else if (accept_s) begin
            d_r         <= divisor;
            q_r         <= dividend;
            r_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            div_by_zero <= zero_div_s;
            if (zero_div_s) begin
                quotient  <= {WIDTH{1'b1}};
                remainder <= dividend;
            end
        end else if (state_r == S_RUN) begin
            r_r   <= r_step_s;
            q_r   <= q_step_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (last_s) begin
                quotient  <= q_step_s;
                remainder <= r_step_s;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, multi-cycle corner
// sequences and randomized operands against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 16;
    localparam int TIMEOUT = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        bit           b2b;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
    task automatic wait_done(input int first_lat, output int lat, output bit busy_ok);
        lat = first_lat;
        busy_ok = 1'b1;
        while (!done && lat < TIMEOUT) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    // Issues a request at the current negedge (DUT in IDLE or DONE) and checks it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input bit b2b);
        int lat;
        bit bok;
        int elat;
        elat = (b == 16'd0) ? 1 : W + 1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
        wait_done(1, lat, bok);
        chk("latency", lat, elat);
        chk("busy_in_run", bok, 1);
        chk("busy_at_done", busy, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        if (!b2b) begin
            @(negedge clk);
            chk("done_width", done, 0);
            chk("quotient_held", quotient, eq);
            chk("dbz_held", div_by_zero, ez);
        end
    endtask

    vec_t tbl[11];

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic         ez;
        int           lat;
        bit           bok;
        bit           saw_done;

        tbl[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,    1'b0, 1'b0};
        tbl[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{16'h0005,  16'h0009,   16'h0000,   16'h0005, 1'b0, 1'b0};
        tbl[3]  = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234, 1'b1, 1'b0};
        tbl[4]  = '{16'd9,     16'd3,      16'd3,      16'd0,    1'b0, 1'b0};
        tbl[5]  = '{16'd0,     16'd5,      16'd0,      16'd0,    1'b0, 1'b0};
        tbl[6]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,    1'b0, 1'b0};
        tbl[7]  = '{16'h8000,  16'd3,      16'h2AAA,   16'd2,    1'b0, 1'b0};
        tbl[8]  = '{16'd1,     16'hFFFF,   16'd0,      16'd1,    1'b0, 1'b0};
        tbl[9]  = '{16'd7,     16'd0,      16'hFFFF,   16'd7,    1'b1, 1'b1};
        tbl[10] = '{16'd200,   16'd10,     16'd20,     16'd0,    1'b0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        dividend = 16'd0;
        divisor = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, including back-to-back issue at DONE
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].b2b);
        end

        // Back-to-back: the cycle after DONE must already be RUN
        start = 1'b1; dividend = 16'hFFFF; divisor = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat, bok);
        start = 1'b1; dividend = 16'h0005; divisor = 16'h0009;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_bubble_busy", busy, 1);
        chk("b2b_no_bubble_done", done, 0);
        wait_done(1, lat, bok);
        chk("b2b_latency", lat, W + 1);
        chk("b2b_quotient", quotient, 16'd0);
        chk("b2b_remainder", remainder, 16'd5);
        @(negedge clk);

        // start during RUN is ignored
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat, bok);
        chk("ign_latency", lat, W + 1);
        chk("ign_busy", bok, 1);
        chk("ign_quotient", quotient, 16'd14);
        chk("ign_remainder", remainder, 16'd2);
        @(negedge clk);
        chk("ign_single_done", done, 0);

        // Reset in cycle 8 of a RUN aborts with no done pulse
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_stays_idle", saw_done, 0);
        run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 2000; i++) begin
            int sel;
            bit b2b;
            sel = $urandom_range(0, 9);
            a = 16'($urandom);
            if (sel == 0)      b = 16'd0;
            else if (sel <= 3) b = 16'($urandom_range(1, 15));
            else               b = 16'($urandom);
            b2b = (i == 1999) ? 1'b0 : 1'($urandom_range(0, 1));
            ref_div(a, b, eq, er, ez);
            run_op(a, b, eq, er, ez, b2b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
